// File: rtl/present_round_ctrl_if.sv
// Bus bundle between present_round_ctrl and its environment.
// Key width follows PRESENT_KEY128_EN (128 bits when defined, 80 otherwise).
interface present_round_ctrl_if;
`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
`else
  localparam int KEY_W = 80;
`endif

  logic             start;
  logic [63:0]      pt;
  logic [KEY_W-1:0] key;
  logic [63:0]      sbox_a;
  logic [63:0]      sbox_y;
  logic [63:0]      rkey;
  logic             busy;
  logic             done;
  logic [63:0]      y;

  modport master (
    output start, pt, key, sbox_y,
    input  sbox_a, rkey, busy, done, y
  );

  modport slave (
    input  start, pt, key, sbox_y,
    output sbox_a, rkey, busy, done, y
  );
endinterface

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT round controller and key schedule feeding an external sboxlayer.
// Define PRESENT_KEY128_EN for the 128-bit key variant; default is the 80-bit key.
module present_round_ctrl #(
  parameter int ROUNDS = 31
) (
  input logic           clk,
  input logic           rst_n,
  present_round_ctrl_if.slave bus
);

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
  localparam int N_SB  = 2;
  localparam int RC_LO = 62;
`else
  localparam int KEY_W = 80;
  localparam int N_SB  = 1;
  localparam int RC_LO = 15;
`endif
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, OUT} fsm_t;

  fsm_t             fsm_reg, fsm_next;
  logic [63:0]      state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic [4:0]       round_reg, round_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [63:0]      y_reg, y_next;

  logic [KEY_W-1:0] key_rot;
  logic [KEY_W-1:0] key_upd;
  logic [4*N_SB-1:0] sb_out;
  logic [63:0]      rkey;
  logic [63:0]      sbox_a;

  assign rkey   = key_reg[KEY_W-1 -: 64];
  assign sbox_a = state_reg ^ rkey;

  assign key_rot = {key_reg[KEY_W-62:0], key_reg[KEY_W-1:KEY_W-61]};

  // Top nibble(s) of the rotated key go through the 4-bit S-box, MSB nibble first.
  genvar gi;
  generate
    for (gi = 0; gi < N_SB; gi++) begin : g_key_sbox
      sboxkeylayer u_sbox (
        .a (key_rot[KEY_W-1-4*gi -: 4]),
        .y (sb_out[4*(N_SB-1-gi) +: 4])
      );
    end
  endgenerate

  always_comb begin
    key_upd                       = key_rot;
    key_upd[KEY_W-1 -: 4*N_SB]    = sb_out;
    key_upd[RC_LO+4:RC_LO]        = key_rot[RC_LO+4:RC_LO] ^ round_reg;
  end

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    key_next   = key_reg;
    round_next = round_reg;
    busy_next  = (fsm_reg != IDLE);
    done_next  = 1'b0;
    y_next     = y_reg;
    case (fsm_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = bus.pt;
          key_next   = bus.key;
          round_next = 5'd1;
          busy_next  = 1'b1;
          fsm_next   = RUN;
        end
      end
      RUN: begin
        state_next = bus.sbox_y;
        key_next   = key_upd;
        if (round_reg == LAST_ROUND) begin
          round_next = 5'd0;
          fsm_next   = OUT;
        end else begin
          round_next = round_reg + 5'd1;
        end
      end
      OUT: begin
        y_next    = sbox_a;
        done_next = 1'b1;
        fsm_next  = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      round_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      y_reg     <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      key_reg   <= key_next;
      round_reg <= round_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      y_reg     <= y_next;
    end
  end

  assign bus.sbox_a = sbox_a;
  assign bus.rkey   = rkey;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.y      = y_reg;

endmodule

// 4-bit PRESENT S-box used by the key schedule.
module sboxkeylayer (
  input  logic [3:0] a,
  output logic [3:0] y
);
  always_comb begin
    case (a)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
  end
endmodule

// File: tb/tb_present_round_ctrl.sv
// Randomized bench for present_round_ctrl against a round-by-round PRESENT reference model;
// the sboxlayer in the loop is modelled here and can be replaced by an all-zero stub.
module tb_present_round_ctrl;

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = 128;
  localparam int RC_LO = 62;
`else
  localparam int KEY_W = 80;
  localparam int RC_LO = 15;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic sbox_stub;

  int checks = 0;
  int errors = 0;

  logic [63:0] model_y;
  logic [63:0] model_rk [1:32];

  present_round_ctrl_if bus ();

  present_round_ctrl #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox4(input logic [3:0] a);
    case (a)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] a);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox4(a[4*i +: 4]);
    return r;
  endfunction

  assign bus.sbox_y = sbox_stub ? 64'd0 : sbox_layer(bus.sbox_a);

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: plain PRESENT iteration, 31 rounds of addRoundKey + sboxlayer, final whitening.
  task automatic model_run(input logic [63:0] pt, input logic [KEY_W-1:0] key, input logic stub);
    logic [63:0]      s;
    logic [KEY_W-1:0] k;
    logic [KEY_W-1:0] rc;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      model_rk[r] = k[KEY_W-1 -: 64];
      s = stub ? 64'd0 : sbox_layer(s ^ k[KEY_W-1 -: 64]);
      k = (k << 61) | (k >> (KEY_W - 61));
      k[KEY_W-1 -: 4] = sbox4(k[KEY_W-1 -: 4]);
`ifdef PRESENT_KEY128_EN
      k[123:120] = sbox4(k[123:120]);
`endif
      rc = '0;
      rc[4:0] = 5'(r);
      k = k ^ (rc << RC_LO);
    end
    model_rk[32] = k[KEY_W-1 -: 64];
    model_y = s ^ model_rk[32];
  endtask

  function automatic logic [KEY_W-1:0] rand_key();
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    return w[KEY_W-1:0];
  endfunction

  // One encryption, entered and left on a sample point (#1 after a rising edge).
  task automatic run_op(input logic [63:0] pt, input logic [KEY_W-1:0] key,
                        input logic stub, input logic inject, input logic zero_key_chk);
    int          n;
    logic        got;
    logic [63:0] out_rkey;
    model_run(pt, key, stub);
    sbox_stub = stub;
    bus.start = 1'b1;
    bus.pt    = pt;
    bus.key   = key;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pt    = {$urandom, $urandom};
    bus.key   = rand_key();
    check_eq("busy_accept", bus.busy, 1);
    check_eq("rkey_round1", bus.rkey, model_rk[1]);
    if (zero_key_chk) check_eq("rkey_zero_r1", bus.rkey, 64'h0000000000000000);
    n = 0;
    got = 1'b0;
    out_rkey = '0;
    while (n < 40 && !got) begin
      if (inject && (n == 10 || n == 31)) begin
        bus.start = 1'b1;
        bus.pt    = {$urandom, $urandom};
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check_eq("rkey_round2", bus.rkey, model_rk[2]);
        if (zero_key_chk) check_eq("rkey_zero_r2", bus.rkey, 64'hC000000000000000);
      end
      if (n == 31) begin
        check_eq("rkey_out", bus.rkey, model_rk[32]);
        out_rkey = bus.rkey;
      end
      if (bus.done) got = 1'b1;
      else if (bus.busy !== 1'b1) check_eq("busy_run", bus.busy, 1);
    end
    bus.start = 1'b0;
    check_eq("done_latency", n, 32);
    check_eq("busy_done_cycle", bus.busy, 1);
    check_eq("y_model", bus.y, model_y);
    if (stub) check_eq("y_stub_rkey", bus.y, out_rkey);
    $display("op pt=%016h key=%0h stub=%0d inj=%0d lat=%0d y=%016h exp=%016h",
             pt, key, stub, inject, n, bus.y, model_y);
  endtask

  task automatic hold_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (i == 0) check_eq("busy_fall", bus.busy, 0);
      check_eq("y_hold", bus.y, model_y);
      check_eq("done_idle", bus.done, 0);
    end
  endtask

  initial begin
    int dones;
    logic [63:0] p;
    rst_n     = 1'b0;
    sbox_stub = 1'b0;
    bus.start = 1'b1;
    bus.pt    = {$urandom, $urandom};
    bus.key   = rand_key();

    // reset held with start asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_y", bus.y, 0);
      check_eq("rst_rkey", bus.rkey, 0);
      check_eq("rst_sbox_a", bus.sbox_a, 0);
      $display("reset cycle %0d busy=%0d done=%0d", i, bus.busy, bus.done);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", bus.busy, 0);

    // zero key/plaintext with the real layer, then hold
    run_op(64'd0, '0, 1'b0, 1'b0, (KEY_W == 80));
    hold_check(10);

    // stubbed layer, arbitrary inputs
    run_op({$urandom, $urandom}, rand_key(), 1'b1, 1'b0, 1'b0);
    hold_check(2);

    // start while busy and during OUT
    run_op({$urandom, $urandom}, rand_key(), 1'b0, 1'b1, 1'b0);
    hold_check(3);

    // randomized back-to-back operations
    for (int i = 0; i < 6; i++) begin
      run_op({$urandom, $urandom}, rand_key(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
    end
    hold_check(2);

    // reset pulse at round 15
    sbox_stub = 1'b0;
    p = {$urandom, $urandom};
    bus.start = 1'b1;
    bus.pt    = p;
    bus.key   = rand_key();
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_rkey", bus.rkey, 0);
    check_eq("abort_y", bus.y, 0);
    dones = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    $display("abort test dones=%0d", dones);
    run_op({$urandom, $urandom}, rand_key(), 1'b0, 1'b0, 1'b0);
    hold_check(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
